soc_event_collector: RTL and testbench
======================================

Name: soc_event_collector

Overview:
- Upstream feeder for the interrupt controller's event FIFO port.
- Captures single-cycle event pulses from up to NUM_EVT peripheral event lines and keeps a saturating pending count per line.
- Round-robin arbitrates pending lines and emits one event ID per transfer on a valid/grant stream. Drives event_fifo_valid_i/event_fifo_data_i of the controller and consumes its event_fifo_fulln_o as grant.

Parameters:
NUM_EVT, 32, number of event input lines (2..64)
EVT_ID_WIDTH, 8, width of emitted event ID
CNT_WIDTH, 2, width of per-line pending counter; max pending = 2^CNT_WIDTH-1
ID_BASE, 0, offset added to line index to form emitted ID

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset; synchronous, active-high
evt_i  in  NUM_EVT  event pulses, one bit per line, each high cycle = one event
evt_mask_i  in  NUM_EVT  1 = line enabled; masked lines never counted
event_fifo_valid_o  out  1  output event valid
event_fifo_data_o  out  EVT_ID_WIDTH  output event ID
event_fifo_grant_i  in  1  downstream can accept (FIFO not full)
ovf_o  out  NUM_EVT  sticky per-line overflow flags
ovf_clr_i  in  NUM_EVT  per-line overflow clear strobe
err_o  out  1  OR of ovf_o
pending_o  out  1  any line has a nonzero count

Behaviour:
- Reset (rst_i high at a clock edge): all counters 0; event_fifo_valid_o=0; event_fifo_data_o=0; ovf_o=0; RR pointer=NUM_EVT-1, so line 0 has first priority. Reset mid-operation discards all pending events and any held output without a handshake.
- Transfer occurs when event_fifo_valid_o && event_fifo_grant_i.
- Output register loads when load = !event_fifo_valid_o || event_fifo_grant_i.
- While valid && !grant, event_fifo_data_o and event_fifo_valid_o stay stable. Once asserted, valid is never dropped without a transfer, except on reset.
- Request: req[k] = cnt[k] != 0.
- On load with any req:
  - winner = first requesting k searching upward from ptr+1 modulo NUM_EVT.
  - data <= ID_BASE+winner, truncated to EVT_ID_WIDTH.
  - valid <= 1; ptr <= winner; cnt[winner] decremented.
- On load with no req: valid <= 0; data holds its last value.
- Counter update per line k, where inc = evt_i[k] & evt_mask_i[k] and dec = (k is the winner this cycle):
  - inc && dec: cnt unchanged, no overflow.
  - inc && !dec && cnt==max: cnt stays at max, the event is dropped, ovf[k] <= 1.
  - inc && !dec && cnt<max: cnt+1.
  - dec only: cnt-1.
- Latency: a pulse on evt_i in cycle t updates cnt at the end of t. With an idle output and grant high, valid_o is high in cycle t+2. Minimum is 2 cycles.
- The arbiter never bypasses same-cycle evt_i.
- Throughput: one event per cycle while grant is held high and requests exist.
- Fairness: a line that keeps requesting is served at most NUM_EVT grants after it first requests.
- ovf[k]: set by overflow, cleared by ovf_clr_i[k]; a same-cycle set wins over clear. err_o = |ovf. pending_o = |req, combinational from the registered counts.
- Masking a line while it has a nonzero count does not flush the count; the remaining events are still emitted.
- No combinational path from event_fifo_grant_i to event_fifo_valid_o or event_fifo_data_o.

Test Plan:
- Reset, then evt_i[5] pulsed 1 cycle at t with grant=1 -> valid high at t+2 with data=5 for one cycle; pending_o=1 in t+1 only; ovf_o=0.
- evt_i[3], evt_i[7] and evt_i[20] pulsed together, grant=1 -> IDs 3, 7, 20 on consecutive cycles. Pulse all three again -> 3, 7, 20 again because the pointer wraps from 20.
- grant=0, evt_i[2] pulsed 5 cycles (CNT_WIDTH=2):
  - valid with data=2 held stable.
  - Counter reaches 3 and ovf_o[2]=1 after the 5th pulse; err_o=1.
  - Release grant -> exactly four ID-2 transfers, then valid=0.
- Same-cycle ovf_clr_i[2]=1 with an overflowing evt_i[2] -> ovf_o[2] stays 1. Clear alone next cycle -> ovf_o[2]=0, err_o=0.
- All 32 lines held high continuously with grant=1 -> IDs cycle 0..31 repeatedly, one per cycle, no line skipped. Toggling grant randomly -> data stable whenever valid && !grant.
- ID_BASE=250, EVT_ID_WIDTH=8, pulse line 10 -> data=4 (wrap). Pulse with evt_mask_i[10]=0 -> nothing emitted. Assert rst_i while valid=1 and grant=0 -> valid=0, pending_o=0 the next cycle.

Source files
------------

// File: rtl/soc_event_collector.sv
// Event pulse collector: per-line saturating pending counters feeding a
// round-robin arbiter that emits one event ID per valid/grant transfer.
module soc_event_collector #(
    parameter int NUM_EVT      = 32,
    parameter int EVT_ID_WIDTH = 8,
    parameter int CNT_WIDTH    = 2,
    parameter int ID_BASE      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_EVT-1:0]      evt_i,
    input  logic [NUM_EVT-1:0]      evt_mask_i,
    output logic                    event_fifo_valid_o,
    output logic [EVT_ID_WIDTH-1:0] event_fifo_data_o,
    input  logic                    event_fifo_grant_i,
    output logic [NUM_EVT-1:0]      ovf_o,
    input  logic [NUM_EVT-1:0]      ovf_clr_i,
    output logic                    err_o,
    output logic                    pending_o
);

    localparam int PTR_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_EVT-1:0]      req;
    logic [NUM_EVT-1:0]      hi_mask;
    logic [NUM_EVT-1:0]      req_hi;
    logic [NUM_EVT-1:0]      sel_vec;
    logic [NUM_EVT-1:0]      ovf_reg;
    logic [PTR_W-1:0]        ptr_reg;
    logic [PTR_W-1:0]        win_idx;
    logic                    valid_reg;
    logic [EVT_ID_WIDTH-1:0] data_reg;
    logic                    load;
    logic                    any_req;

    assign load    = !valid_reg || event_fifo_grant_i;
    assign any_req = |req;

    // Lines above the pointer get first pick; otherwise wrap to the lowest requester.
    assign req_hi  = req & hi_mask;
    assign sel_vec = (|req_hi) ? req_hi : req;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_line
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 ovf_bit_reg;
            logic                 inc;
            logic                 dec;
            logic                 ovf_set;

            assign hi_mask[gi] = (PTR_W'(gi) > ptr_reg);
            assign req[gi]     = (cnt_reg != '0);
            assign inc         = evt_i[gi] & evt_mask_i[gi];
            assign dec         = load && any_req && (win_idx == PTR_W'(gi));
            assign ovf_set     = inc && !dec && (cnt_reg == CNT_MAX);
            assign ovf_reg[gi] = ovf_bit_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg     <= '0;
                    ovf_bit_reg <= 1'b0;
                end else begin
                    if (inc && !dec && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (dec && !inc) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                    // A fresh overflow outranks a simultaneous clear.
                    if (ovf_set) begin
                        ovf_bit_reg <= 1'b1;
                    end else if (ovf_clr_i[gi]) begin
                        ovf_bit_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ptr_reg   <= PTR_W'(NUM_EVT - 1);
        end else if (load) begin
            if (any_req) begin
                valid_reg <= 1'b1;
                data_reg  <= EVT_ID_WIDTH'(ID_BASE + int'(win_idx));
                ptr_reg   <= win_idx;
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign event_fifo_valid_o = valid_reg;
    assign event_fifo_data_o  = data_reg;
    assign ovf_o              = ovf_reg;
    assign err_o              = |ovf_reg;
    assign pending_o          = any_req;

endmodule

// File: tb/tb_soc_event_collector.sv
// Bench for soc_event_collector: table vectors, directed corner sequences and
// random traffic, all checked against a cycle-level behavioural model.
module tb_soc_event_collector;

    localparam int N    = 32;
    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] evt, mask, clr;
    logic        grant;
    logic        valid, b_valid;
    logic [7:0]  data, b_data;
    logic [31:0] ovf, b_ovf;
    logic        err, b_err, pending, b_pending;

    always #5 clk = ~clk;

    soc_event_collector #(.NUM_EVT(N), .EVT_ID_WIDTH(8), .CNT_WIDTH(2), .ID_BASE(0)) dut (
        .clk_i(clk), .rst_i(rst), .evt_i(evt), .evt_mask_i(mask),
        .event_fifo_valid_o(valid), .event_fifo_data_o(data),
        .event_fifo_grant_i(grant), .ovf_o(ovf), .ovf_clr_i(clr),
        .err_o(err), .pending_o(pending)
    );

    soc_event_collector #(.NUM_EVT(N), .EVT_ID_WIDTH(8), .CNT_WIDTH(2), .ID_BASE(250)) dut_b (
        .clk_i(clk), .rst_i(rst), .evt_i(evt), .evt_mask_i(mask),
        .event_fifo_valid_o(b_valid), .event_fifo_data_o(b_data),
        .event_fifo_grant_i(grant), .ovf_o(b_ovf), .ovf_clr_i(clr),
        .err_o(b_err), .pending_o(b_pending)
    );

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int last_id = -1;

    // Behavioural model state
    int          m_cnt [N];
    int          m_ptr;
    logic        m_valid;
    logic [7:0]  m_data, m_data_b;
    logic [31:0] m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  win;
        bit  ld, inc, dec, set;
        if (rst) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_ptr = N - 1; m_valid = 1'b0; m_data = 8'd0; m_data_b = 8'd0; m_ovf = '0;
            return;
        end
        ld  = !m_valid || grant;
        win = -1;
        if (ld) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (win < 0 && m_cnt[k] > 0) win = k;
            end
        end
        for (int k = 0; k < N; k++) begin
            inc = evt[k] && mask[k];
            dec = (k == win);
            set = 1'b0;
            if (inc && !dec) begin
                if (m_cnt[k] == MAXC) begin
                    set = 1'b1;
                    m_ovf[k] = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end else if (dec && !inc) begin
                m_cnt[k] = m_cnt[k] - 1;
            end
            if (!set && clr[k]) m_ovf[k] = 1'b0;
        end
        if (ld) begin
            if (win >= 0) begin
                m_valid  = 1'b1;
                m_data   = 8'(win);
                m_data_b = 8'((250 + win) % 256);
                m_ptr    = win;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    function automatic logic model_pending();
        foreach (m_cnt[k]) if (m_cnt[k] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: capture pre-edge handshake, advance model, compare at negedge.
    task automatic step();
        logic       pv, pg, prst;
        logic [7:0] pd;
        pv = valid; pg = grant; pd = data; prst = rst;
        if (pv && pg && !prst) begin
            xfers++;
            last_id = int'(pd);
            $display("xfer id=%0d at %0t", pd, $time);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("valid", valid, m_valid);
        chk("data", data, m_data);
        chk("b_valid", b_valid, m_valid);
        chk("b_data", b_data, m_data_b);
        chk("pending", pending, model_pending());
        chk("ovf", ovf, m_ovf);
        chk("err", err, |m_ovf);
        if (pv && !pg && !prst) begin
            chk("hold_valid", valid, 1'b1);
            chk("hold_data", data, pd);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] evt;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_pending;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int prevd;
        logic [31:0] tri_evt;
        tri_evt = 32'h0010_0088;  // lines 3, 7, 20
        vecs[0]  = '{1'b0, 32'h20,    1'b0, 8'd0,  1'b1};
        vecs[1]  = '{1'b0, 32'h0,     1'b1, 8'd5,  1'b0};
        vecs[2]  = '{1'b0, 32'h0,     1'b0, 8'd5,  1'b0};
        vecs[3]  = '{1'b1, 32'h0,     1'b0, 8'd0,  1'b0};
        vecs[4]  = '{1'b0, tri_evt,   1'b0, 8'd0,  1'b1};
        vecs[5]  = '{1'b0, 32'h0,     1'b1, 8'd3,  1'b1};
        vecs[6]  = '{1'b0, 32'h0,     1'b1, 8'd7,  1'b1};
        vecs[7]  = '{1'b0, 32'h0,     1'b1, 8'd20, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,     1'b0, 8'd20, 1'b0};
        vecs[9]  = '{1'b0, tri_evt,   1'b0, 8'd20, 1'b1};
        vecs[10] = '{1'b0, 32'h0,     1'b1, 8'd3,  1'b1};
        vecs[11] = '{1'b0, 32'h0,     1'b1, 8'd7,  1'b1};
        vecs[12] = '{1'b0, 32'h0,     1'b1, 8'd20, 1'b0};
        vecs[13] = '{1'b0, 32'h0,     1'b0, 8'd20, 1'b0};

        rst = 1'b1; evt = '0; mask = '1; grant = 1'b1; clr = '0;
        step();
        step();
        chk("reset_valid", valid, 1'b0);
        chk("reset_data", data, 8'd0);
        chk("reset_ovf", ovf, 32'd0);
        chk("reset_pending", pending, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; evt = vecs[i].evt; grant = 1'b1;
            step();
            chk($sformatf("tbl%0d_valid", i), valid, vecs[i].exp_valid);
            chk($sformatf("tbl%0d_data", i), data, vecs[i].exp_data);
            chk($sformatf("tbl%0d_pending", i), pending, vecs[i].exp_pending);
        end
        rst = 1'b0; evt = '0;

        // Saturation with output stalled
        grant = 1'b0; evt = 32'h4;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 3) chk("ovf_before_sat", ovf[2], 1'b0);
        end
        chk("ovf_sat_bit", ovf[2], 1'b1);
        chk("ovf_sat_err", err, 1'b1);
        chk("ovf_sat_valid", valid, 1'b1);
        chk("ovf_sat_data", data, 8'd2);
        evt = '0; grant = 1'b1; xfers = 0;
        repeat (8) step();
        chk("ovf_drain_count", xfers, 4);
        chk("ovf_drain_last_id", last_id, 2);
        chk("ovf_drain_idle", valid, 1'b0);

        // Clear versus simultaneous overflow
        grant = 1'b0; clr = 32'h4;
        step();
        chk("clr_alone_a", ovf[2], 1'b0);
        clr = '0; evt = 32'h4;
        repeat (4) step();
        clr = 32'h4;
        step();
        chk("clr_vs_set", ovf[2], 1'b1);
        evt = '0;
        step();
        chk("clr_alone_b", ovf[2], 1'b0);
        chk("clr_alone_err", err, 1'b0);
        clr = '0; grant = 1'b1;
        repeat (6) step();

        // All lines busy: strict rotation
        evt = '1; prevd = -1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (prevd >= 0) chk("rr_valid", valid, 1'b1);
            if (valid) begin
                if (prevd >= 0) chk("rr_seq", data, 8'((prevd + 1) % N));
                prevd = int'(data);
            end
        end
        for (int i = 0; i < 60; i++) begin
            grant = 1'($urandom_range(0, 1));
            step();
        end
        evt = '0; clr = '1; grant = 1'b1;
        repeat (110) step();
        clr = '0;
        chk("drain_idle", valid, 1'b0);

        // ID offset wrap, masking, reset with held output
        rst = 1'b1; step(); rst = 1'b0;
        evt = 32'h400;
        step();
        evt = '0;
        step();
        chk("wrap_b_data", b_data, 8'd4);
        chk("wrap_data", data, 8'd10);
        step();
        mask = ~32'h400; evt = 32'h400;
        step();
        evt = '0;
        repeat (3) begin
            step();
            chk("masked_valid", valid, 1'b0);
            chk("masked_pending", pending, 1'b0);
        end
        mask = '1; grant = 1'b0; evt = 32'h400;
        step();
        evt = '0;
        step();
        chk("pre_rst_valid", valid, 1'b1);
        rst = 1'b1;
        step();
        chk("rst_mid_valid", valid, 1'b0);
        chk("rst_mid_pending", pending, 1'b0);
        rst = 1'b0; grant = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            evt   = $urandom & $urandom & $urandom;
            mask  = ~($urandom & $urandom & $urandom);
            grant = ($urandom_range(0, 3) != 0);
            clr   = $urandom & $urandom & $urandom & $urandom;
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
